// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared pipeline widths, forward-select codes and ID/EX record type.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int RW_DEFAULT   = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                    valid;
        logic                    reg_write;
        logic                    mem_read;
        logic                    alu_src;
        logic [RW_DEFAULT-1:0]   rs1;
        logic [RW_DEFAULT-1:0]   rs2;
        logic [RW_DEFAULT-1:0]   rd;
        logic [XLEN_DEFAULT-1:0] read_reg1;
        logic [XLEN_DEFAULT-1:0] read_reg2;
        logic [XLEN_DEFAULT-1:0] imm;
    } id_ex_t;

endpackage

`default_nettype wire

// File: rtl/forward_unit.sv
// ============================================================================
// Module : forward_unit
// Brief  : Selects the EX operand source for one source register.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module forward_unit
    import pipe_pkg::*;
#(
    parameter int RW = RW_DEFAULT
) (
    input  logic          ex_valid_i,
    input  logic [RW-1:0] ex_rs_i,
    input  logic [RW-1:0] ex_mem_rd_i,
    input  logic          ex_mem_reg_write_i,
    input  logic [RW-1:0] mem_wb_rd_i,
    input  logic          mem_wb_reg_write_i,
    output logic [1:0]    fwd_sel_o
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = ex_mem_reg_write_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == ex_rs_i);
    assign w_wb_hit  = mem_wb_reg_write_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == ex_rs_i);

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    always_comb begin
        fwd_sel_o = FWD_REG;
        if (ex_valid_i) begin
            if (w_mem_hit) begin
                fwd_sel_o = FWD_MEM;
            end else if (w_wb_hit) begin
                fwd_sel_o = FWD_WB;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_forward.sv
// ============================================================================
// Module : id_ex_forward
// Brief  : ID/EX pipeline register with load-use stall, WB bypass and forwarding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_forward
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int RW   = RW_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [RW-1:0]   id_rs1,
    input  logic [RW-1:0]   id_rs2,
    input  logic [RW-1:0]   id_rd,
    input  logic [XLEN-1:0] id_read_reg1,
    input  logic [XLEN-1:0] id_read_reg2,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_alu_src,
    input  logic            flush,
    input  logic [RW-1:0]   ex_mem_rd,
    input  logic            ex_mem_reg_write,
    input  logic [RW-1:0]   mem_wb_rd,
    input  logic            mem_wb_reg_write,
    input  logic [XLEN-1:0] mem_wb_data,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_alu_src,
    output logic [RW-1:0]   ex_rs1,
    output logic [RW-1:0]   ex_rs2,
    output logic [RW-1:0]   ex_rd,
    output logic [XLEN-1:0] ex_read_reg1,
    output logic [XLEN-1:0] ex_read_reg2,
    output logic [XLEN-1:0] ex_imm,
    output logic [1:0]      forward_A,
    output logic [1:0]      forward_B,
    output logic            stall
);

    // Width-parameterised mirror of pipe_pkg::id_ex_t.
    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_read;
        logic            alu_src;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] read_reg1;
        logic [XLEN-1:0] read_reg2;
        logic [XLEN-1:0] imm;
    } ex_regs_t;

    ex_regs_t ex_q;
    ex_regs_t ex_d;

    logic w_stall;
    logic w_bubble;
    logic w_byp1;
    logic w_byp2;

    assign w_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                     ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

    assign w_bubble = w_stall || flush || !id_valid;

    // A register being written back this cycle is not yet in the ID read data.
    assign w_byp1 = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == id_rs1);
    assign w_byp2 = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == id_rs2);

    always_comb begin
        ex_d = '0;
        if (!w_bubble) begin
            ex_d.valid     = 1'b1;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_d.alu_src   = id_alu_src;
            ex_d.rs1       = id_rs1;
            ex_d.rs2       = id_rs2;
            ex_d.rd        = id_rd;
            ex_d.read_reg1 = w_byp1 ? mem_wb_data : id_read_reg1;
            ex_d.read_reg2 = w_byp2 ? mem_wb_data : id_read_reg2;
            ex_d.imm       = id_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    forward_unit #(.RW(RW)) u_fwd_a (
        .ex_valid_i         (ex_q.valid),
        .ex_rs_i            (ex_q.rs1),
        .ex_mem_rd_i        (ex_mem_rd),
        .ex_mem_reg_write_i (ex_mem_reg_write),
        .mem_wb_rd_i        (mem_wb_rd),
        .mem_wb_reg_write_i (mem_wb_reg_write),
        .fwd_sel_o          (forward_A)
    );

    forward_unit #(.RW(RW)) u_fwd_b (
        .ex_valid_i         (ex_q.valid),
        .ex_rs_i            (ex_q.rs2),
        .ex_mem_rd_i        (ex_mem_rd),
        .ex_mem_reg_write_i (ex_mem_reg_write),
        .mem_wb_rd_i        (mem_wb_rd),
        .mem_wb_reg_write_i (mem_wb_reg_write),
        .fwd_sel_o          (forward_B)
    );

    assign stall        = w_stall;
    assign ex_valid     = ex_q.valid;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_alu_src   = ex_q.alu_src;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rd        = ex_q.rd;
    assign ex_read_reg1 = ex_q.read_reg1;
    assign ex_read_reg2 = ex_q.read_reg2;
    assign ex_imm       = ex_q.imm;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_forward.sv
// ============================================================================
// Module : tb_id_ex_forward
// Brief  : Directed vector table plus a short combinational stall sequence.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_forward;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_read_reg1, id_read_reg2, id_imm;
    logic        id_reg_write, id_mem_read, id_alu_src;
    logic        flush;
    logic [4:0]  ex_mem_rd, mem_wb_rd;
    logic        ex_mem_reg_write, mem_wb_reg_write;
    logic [31:0] mem_wb_data;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_alu_src;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_read_reg1, ex_read_reg2, ex_imm;
    logic [1:0]  forward_A, forward_B;
    logic        stall;

    always #5 clk = ~clk;

    id_ex_forward #(.XLEN(32), .RW(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_valid         (id_valid),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_rd            (id_rd),
        .id_read_reg1     (id_read_reg1),
        .id_read_reg2     (id_read_reg2),
        .id_imm           (id_imm),
        .id_reg_write     (id_reg_write),
        .id_mem_read      (id_mem_read),
        .id_alu_src       (id_alu_src),
        .flush            (flush),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_reg_write (mem_wb_reg_write),
        .mem_wb_data      (mem_wb_data),
        .ex_valid         (ex_valid),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_read      (ex_mem_read),
        .ex_alu_src       (ex_alu_src),
        .ex_rs1           (ex_rs1),
        .ex_rs2           (ex_rs2),
        .ex_rd            (ex_rd),
        .ex_read_reg1     (ex_read_reg1),
        .ex_read_reg2     (ex_read_reg2),
        .ex_imm           (ex_imm),
        .forward_A        (forward_A),
        .forward_B        (forward_B),
        .stall            (stall)
    );

    // ctl = {reg_write, mem_read, alu_src}; xctl = {valid, reg_write, mem_read, alu_src}
    typedef struct {
        string       name;
        logic        rst, fl, idv;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] r1, r2, imm;
        logic [2:0]  ctl;
        logic [4:0]  emrd;
        logic        emrw;
        logic [4:0]  mwrd;
        logic        mwrw;
        logic [31:0] mwd;
        logic        xstall;
        logic [3:0]  xctl;
        logic [31:0] xr1, xr2;
        logic [1:0]  xfa, xfb;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(string nm, logic rst, logic fl, logic idv,
                                logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic [31:0] r1, logic [31:0] r2, logic [31:0] imm, logic [2:0] ctl,
                                logic [4:0] emrd, logic emrw, logic [4:0] mwrd, logic mwrw, logic [31:0] mwd,
                                logic xstall, logic [3:0] xctl, logic [31:0] xr1, logic [31:0] xr2,
                                logic [1:0] xfa, logic [1:0] xfb);
        vec_t v;
        v.name = nm; v.rst = rst; v.fl = fl; v.idv = idv;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.r1 = r1; v.r2 = r2; v.imm = imm; v.ctl = ctl;
        v.emrd = emrd; v.emrw = emrw; v.mwrd = mwrd; v.mwrw = mwrw; v.mwd = mwd;
        v.xstall = xstall; v.xctl = xctl; v.xr1 = xr1; v.xr2 = xr2; v.xfa = xfa; v.xfb = xfb;
        return v;
    endfunction

    task automatic chk(input string vn, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", vn, fld, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset            = v.rst;
        flush            = v.fl;
        id_valid         = v.idv;
        id_rs1           = v.rs1;
        id_rs2           = v.rs2;
        id_rd            = v.rd;
        id_read_reg1     = v.r1;
        id_read_reg2     = v.r2;
        id_imm           = v.imm;
        {id_reg_write, id_mem_read, id_alu_src} = v.ctl;
        ex_mem_rd        = v.emrd;
        ex_mem_reg_write = v.emrw;
        mem_wb_rd        = v.mwrd;
        mem_wb_reg_write = v.mwrw;
        mem_wb_data      = v.mwd;
    endtask

    initial begin
        vec_t v;
        v = mk("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        drive(v);
        repeat (2) @(posedge clk);

        //            name                 rst fl idv rs1 rs2 rd  r1      r2     imm    ctl     emrd emrw mwrd mwrw mwd            stall xctl     xr1      xr2            fa     fb
        tbl.push_back(mk("reset_hold",        1, 0, 1,  1,  2,  3, 'h11,  'h22,  'h33,  3'b111, 0, 0, 0, 0, 0,             0, 4'b0000, 0,       0,             2'b00, 2'b00));
        tbl.push_back(mk("add_x5",            0, 0, 1,  1,  2,  5, 'h10,  'h20,  'h05,  3'b100, 0, 0, 0, 0, 0,             0, 4'b1100, 'h10,    'h20,          2'b00, 2'b00));
        tbl.push_back(mk("sub_x6_x1_x5",      0, 0, 1,  1,  5,  6, 'h30,  'h40,  'h06,  3'b100, 5, 1, 0, 0, 0,             0, 4'b1100, 'h30,    'h40,          2'b00, 2'b10));
        tbl.push_back(mk("two_apart",         0, 0, 1,  2,  5,  8, 'h01,  'h02,  'h07,  3'b100, 7, 0, 5, 1, 'hAAAA,        0, 4'b1100, 'h01,    'hAAAA,        2'b00, 2'b01));
        tbl.push_back(mk("both_match",        0, 0, 1,  5,  5,  9, 'h03,  'h04,  'h08,  3'b101, 5, 1, 5, 1, 'hBBBB,        0, 4'b1101, 'hBBBB,  'hBBBB,        2'b10, 2'b10));
        tbl.push_back(mk("lw_x3",             0, 0, 1,  1,  0,  3, 'h100, 0,     'h10,  3'b111, 0, 0, 0, 0, 0,             0, 4'b1111, 'h100,   0,             2'b00, 2'b00));
        tbl.push_back(mk("use_x3_stall",      0, 0, 1,  3,  4, 10, 'h50,  'h60,  'h11,  3'b100, 0, 0, 0, 0, 0,             1, 4'b0000, 0,       0,             2'b00, 2'b00));
        tbl.push_back(mk("use_x3_enter",      0, 0, 1,  3,  4, 10, 'h50,  'h60,  'h11,  3'b100, 0, 0, 3, 1, 'hCAFE,        0, 4'b1100, 'hCAFE,  'h60,          2'b01, 2'b00));
        tbl.push_back(mk("x0_no_fwd",         0, 0, 1,  0,  0,  0, 'h07,  'h08,  'h12,  3'b100, 0, 1, 0, 1, 'hFFFF,        0, 4'b1100, 'h07,    'h08,          2'b00, 2'b00));
        tbl.push_back(mk("lw_x0",             0, 0, 1,  1,  2,  0, 'h01,  'h02,  'h13,  3'b111, 0, 0, 0, 0, 0,             0, 4'b1111, 'h01,    'h02,          2'b00, 2'b00));
        tbl.push_back(mk("use_x0_no_stall",   0, 0, 1,  0,  0,  4, 'h09,  'h0A,  'h14,  3'b100, 0, 0, 0, 0, 0,             0, 4'b1100, 'h09,    'h0A,          2'b00, 2'b00));
        tbl.push_back(mk("wb_bypass",         0, 0, 1,  1,  9,  2, 'h55,  0,     'h15,  3'b100, 0, 0, 9, 1, 'hDEADBEEF,    0, 4'b1100, 'h55,    'hDEADBEEF,    2'b00, 2'b01));
        tbl.push_back(mk("flush",             0, 1, 1,  1,  2,  3, 'h01,  'h02,  'h16,  3'b111, 0, 0, 0, 0, 0,             0, 4'b0000, 0,       0,             2'b00, 2'b00));
        tbl.push_back(mk("id_invalid",        0, 0, 0,  1,  2,  4, 'h03,  'h04,  'h17,  3'b100, 0, 0, 0, 0, 0,             0, 4'b0000, 0,       0,             2'b00, 2'b00));
        tbl.push_back(mk("lw_x7",             0, 0, 1,  0,  0,  7, 0,     0,     'h18,  3'b111, 0, 0, 0, 0, 0,             0, 4'b1111, 0,       0,             2'b00, 2'b00));
        tbl.push_back(mk("flush_and_stall",   0, 1, 1,  1,  7,  8, 'h21,  'h22,  'h19,  3'b100, 0, 0, 0, 0, 0,             1, 4'b0000, 0,       0,             2'b00, 2'b00));
        tbl.push_back(mk("lw_x7_again",       0, 0, 1,  0,  0,  7, 0,     0,     'h1A,  3'b111, 0, 0, 0, 0, 0,             0, 4'b1111, 0,       0,             2'b00, 2'b00));
        tbl.push_back(mk("reset_in_stall",    1, 0, 1,  7,  2,  8, 'h70,  'h80,  'h1B,  3'b100, 0, 0, 0, 0, 0,             1, 4'b0000, 0,       0,             2'b00, 2'b00));
        tbl.push_back(mk("post_reset_capture",0, 0, 1,  7,  2,  8, 'h70,  'h80,  'h1B,  3'b100, 0, 0, 0, 0, 0,             0, 4'b1100, 'h70,    'h80,          2'b00, 2'b00));
        tbl.push_back(mk("no_write_no_fwd",   0, 0, 1,  6,  6,  1, 'h61,  'h62,  'h1C,  3'b000, 6, 0, 6, 0, 'h1234,        0, 4'b1000, 'h61,    'h62,          2'b00, 2'b00));
        tbl.push_back(mk("lw_x5",             0, 0, 1,  0,  0,  5, 0,     0,     'h1D,  3'b111, 0, 0, 0, 0, 0,             0, 4'b1111, 0,       0,             2'b00, 2'b00));

        foreach (tbl[i]) begin
            v = tbl[i];
            @(negedge clk);
            drive(v);
            #1;
            chk(v.name, "stall", {31'd0, stall}, {31'd0, v.xstall});
            @(posedge clk);
            #1;
            n_vec++;
            chk(v.name, "ctl",   {28'd0, ex_valid, ex_reg_write, ex_mem_read, ex_alu_src}, {28'd0, v.xctl});
            chk(v.name, "rs1",   {27'd0, ex_rs1}, v.xctl[3] ? {27'd0, v.rs1} : 32'd0);
            chk(v.name, "rs2",   {27'd0, ex_rs2}, v.xctl[3] ? {27'd0, v.rs2} : 32'd0);
            chk(v.name, "rd",    {27'd0, ex_rd},  v.xctl[3] ? {27'd0, v.rd}  : 32'd0);
            chk(v.name, "imm",   ex_imm,          v.xctl[3] ? v.imm : 32'd0);
            chk(v.name, "rreg1", ex_read_reg1, v.xr1);
            chk(v.name, "rreg2", ex_read_reg2, v.xr2);
            chk(v.name, "fwdA",  {30'd0, forward_A}, {30'd0, v.xfa});
            chk(v.name, "fwdB",  {30'd0, forward_B}, {30'd0, v.xfb});
        end

        // EX now holds lw x5: stall must track ID operands combinationally.
        @(negedge clk);
        id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd1;
        #1 chk("comb_stall", "rs1_hit", {31'd0, stall}, 32'd1);
        id_rs1 = 5'd1; id_rs2 = 5'd5;
        #1 chk("comb_stall", "rs2_hit", {31'd0, stall}, 32'd1);
        id_rs2 = 5'd2;
        #1 chk("comb_stall", "no_hit", {31'd0, stall}, 32'd0);
        id_rs2 = 5'd5; id_valid = 1'b0;
        #1 chk("comb_stall", "id_invalid", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        n_vec++;
        chk("comb_stall", "bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("comb_stall", "bubble_fwdB", {30'd0, forward_B}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_forward.md
ID_EX_FORWARD -- requirements
Module: id_ex_forward

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter RW, default 5, register-index width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have inputs id_valid (1), id_rs1/id_rs2/id_rd (RW), id_read_reg1/id_read_reg2/id_imm (XLEN), id_reg_write/id_mem_read/id_alu_src (1): decoded ID-stage instruction.
REQ-006 SHALL have input flush (1): branch/jump redirect; kill the instruction entering EX.
REQ-007 SHALL have inputs ex_mem_rd (RW), ex_mem_reg_write (1), mem_wb_rd (RW), mem_wb_reg_write (1), mem_wb_data (XLEN): downstream writeback info.
REQ-008 SHALL have outputs ex_valid, ex_reg_write, ex_mem_read, ex_alu_src (1 each); ex_rs1/ex_rs2/ex_rd (RW); ex_read_reg1/ex_read_reg2/ex_imm (XLEN): registered EX-stage instruction.
REQ-009 SHALL have outputs forward_A, forward_B (2 each): operand-select codes for the EX operand muxes.
REQ-010 SHALL have output stall (1): hold PC and IF/ID this cycle.

Function
REQ-011 Pipeline register SHALL capture all id_* fields every clock unless a bubble is inserted; latency ID->EX exactly 1 cycle.
REQ-012 stall SHALL be combinational: ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-013 Bubble SHALL be inserted when stall=1 or flush=1: ex_valid, ex_reg_write, ex_mem_read cleared; other fields don't-care but SHALL be zeroed.
REQ-014 flush and stall together SHALL produce one bubble; stall output still asserts (flush owner redirects PC).
REQ-015 id_valid=0 SHALL load a bubble (same as REQ-013).
REQ-016 WB bypass at capture: if mem_wb_reg_write & mem_wb_rd!=0 & mem_wb_rd==id_rs1, ex_read_reg1 SHALL latch mem_wb_data instead of id_read_reg1; likewise rs2/ex_read_reg2.
REQ-017 forward_B SHALL be combinational from registered ex_rs2: 2'b10 if ex_mem_reg_write & ex_mem_rd!=0 & ex_mem_rd==ex_rs2; else 2'b01 if mem_wb_reg_write & mem_wb_rd!=0 & mem_wb_rd==ex_rs2; else 2'b00.
REQ-018 forward_A SHALL follow REQ-017 using ex_rs1.
REQ-019 EX/MEM match SHALL take priority over MEM/WB when both match (newest value).
REQ-020 forward_A/forward_B SHALL be 2'b00 whenever ex_valid=0; code 2'b11 SHALL never be driven.
REQ-021 Register x0 (index 0) SHALL never trigger forwarding, bypass, or stall.

Reset
REQ-022 While reset=1 at a clock edge, all EX registers SHALL clear to 0 (ex_valid=0, all fields 0); reset overrides flush, stall and id inputs.
REQ-023 After reset, stall=0 and forward_A=forward_B=2'b00 until a valid instruction is captured.
REQ-024 Reset asserted mid-stall SHALL drop the held hazard; first post-reset instruction captured normally.

Structure
REQ-025 Shared package pipe_pkg SHALL hold XLEN/RW defaults, forward-select constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and struct id_ex_t grouping the registered fields.
REQ-026 Forwarding compare logic SHALL be one combinational sub-module forward_unit instantiated twice (rs1, rs2); register and hazard logic stay in id_ex_forward.

Verification
REQ-027 Back-to-back ALU: add x5 then sub x6,x1,x5; EX/MEM rd=5 reg_write=1, ex_rs2=5 -> forward_B=2'b10, stall=0.
REQ-028 Two-apart dependency: ex_mem_rd=7 reg_write=0, mem_wb_rd=5 reg_write=1, ex_rs2=5 -> forward_B=2'b01; both match rd=5 -> 2'b10.
REQ-029 Load-use: EX holds lw x3 (mem_read=1), ID reads rs1=3 -> stall=1 one cycle, next ex_valid=0, following cycle instruction enters EX with forward_A=2'b01 when mem_wb_rd=3.
REQ-030 x0: ex_mem_rd=0 reg_write=1, ex_rs1=0 -> forward_A=2'b00; lw x0 with ID rs1=0 -> stall=0.
REQ-031 WB bypass: mem_wb_rd=9 data=32'hDEADBEEF, id_rs2=9, id_read_reg2=0 -> next cycle ex_read_reg2=32'hDEADBEEF.
REQ-032 Flush+reset: flush=1 -> next ex_valid=0, ex_reg_write=0; reset=1 during stall -> all outputs 0 next cycle.
